uart_fifo: RTL and testbench

Byte buffer between the CPU-side bus logic and the `rxtx` UART core. Transmit bytes are queued in a TX FIFO and fed to `rxtx` through its `tx_vld`/`tx_data`/`txrdy` handshake, one byte per frame. Received bytes (`rx_vld`/`rx_data` pulses) are queued in an RX FIFO that software drains at its own pace, with sticky overrun reporting. Both FIFOs are first-word-fall-through ring buffers in one clock domain.

---
 rtl/uart_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Byte buffer between the bus side and the rxtx UART core: a TX FIFO feeding rxtx through
// a start-pulse handshake, and an RX FIFO with sticky overrun reporting. Both FIFOs are
// first-word-fall-through ring buffers in the same clock domain.
module uart_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_data_i,
    output logic                  tx_full_o,
    output logic [DEPTH_LOG2:0]   tx_level_o,
    input  logic                  rd_en_i,
    output logic [7:0]            rd_data_o,
    output logic                  rx_empty_o,
    output logic [DEPTH_LOG2:0]   rx_level_o,
    output logic                  rx_overrun_o,
    input  logic                  ovr_clr_i,
    output logic                  tx_vld_o,
    output logic [7:0]            tx_data_o,
    input  logic                  txrdy_i,
    input  logic                  rx_vld_i,
    input  logic [7:0]            rx_data_i
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CntFull = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {StIdle, StSend, StBusy} tx_state_e;

    // ---------------- TX FIFO ----------------
    logic [7:0]            tx_mem_q [Depth];
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    logic                  tx_push, tx_pop, tx_full;
    tx_state_e             tx_state_q, tx_state_d;
    logic                  tx_vld_q, tx_vld_d;
    logic [7:0]            tx_data_q, tx_data_d;

    assign tx_full = (tx_cnt_q == CntFull);
    // A push into a full FIFO is still accepted when the FSM frees the head in the same cycle.
    assign tx_push = wr_en_i && (!tx_full || tx_pop);

    // TX storage write port
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= wr_data_i;
    end

    // TX occupancy follows the push/pop pair
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CntOne;
            2'b01:   tx_cnt_d = tx_cnt_q - CntOne;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // TX pointers and count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // TX FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_state_q <= StIdle;
        else       tx_state_q <= tx_state_d;
    end

    // TX FSM next state; SEND waits for txrdy to drop so a stale high cannot relaunch
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            StIdle:  if (tx_cnt_q != '0 && txrdy_i) tx_state_d = StSend;
            StSend:  if (!txrdy_i) tx_state_d = StBusy;
            StBusy:  if (txrdy_i) tx_state_d = StIdle;
            default: tx_state_d = StIdle;
        endcase
    end

    // TX FSM outputs: launch pops the head and presents it for exactly one cycle
    always_comb begin
        tx_pop    = (tx_state_q == StIdle) && (tx_cnt_q != '0) && txrdy_i;
        tx_vld_d  = tx_pop;
        tx_data_d = tx_pop ? tx_mem_q[tx_rptr_q] : 8'h00;
    end

    // Registered handshake toward rxtx
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_vld_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_vld_o   = tx_vld_q;
    assign tx_data_o  = tx_data_q;
    assign tx_full_o  = tx_full;
    assign tx_level_o = tx_cnt_q;

    // ---------------- RX FIFO ----------------
    logic [7:0]            rx_mem_q [Depth];
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    logic                  rx_push, rx_pop, rx_full, rx_empty, ovr_set;
    logic                  ovr_q, ovr_d;

    assign rx_full  = (rx_cnt_q == CntFull);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = rd_en_i && !rx_empty;
    // A full FIFO still takes a byte if software pops in the same cycle.
    assign rx_push  = rx_vld_i && (!rx_full || rd_en_i);
    assign ovr_set  = rx_vld_i && rx_full && !rd_en_i;

    // RX storage write port
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
    end

    // RX occupancy and overrun next state; a new overrun wins over a clear
    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CntOne;
            2'b01:   rx_cnt_d = rx_cnt_q - CntOne;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        ovr_d = ovr_set || (ovr_q && !ovr_clr_i);
    end

    // RX pointers, count and overrun flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            ovr_q     <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
            rx_cnt_q <= rx_cnt_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rd_data_o    = rx_mem_q[rx_rptr_q];
    assign rx_empty_o   = rx_empty;
    assign rx_level_o   = rx_cnt_q;
    assign rx_overrun_o = ovr_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: queue-based reference model, an rxtx transmitter
// emulator driving txrdy, directed scenarios with literal expectations, then random traffic.
module tb_uart_fifo;

    localparam int unsigned DL2   = 4;
    localparam int          DEPTH = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           wr_en_i = 1'b0;
    logic [7:0]     wr_data_i = 8'h00;
    logic           tx_full_o;
    logic [DL2:0]   tx_level_o;
    logic           rd_en_i = 1'b0;
    logic [7:0]     rd_data_o;
    logic           rx_empty_o;
    logic [DL2:0]   rx_level_o;
    logic           rx_overrun_o;
    logic           ovr_clr_i = 1'b0;
    logic           tx_vld_o;
    logic [7:0]     tx_data_o;
    logic           txrdy_i = 1'b1;
    logic           rx_vld_i = 1'b0;
    logic [7:0]     rx_data_i = 8'h00;

    uart_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .tx_full_o(tx_full_o), .tx_level_o(tx_level_o), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .rx_empty_o(rx_empty_o), .rx_level_o(rx_level_o),
        .rx_overrun_o(rx_overrun_o), .ovr_clr_i(ovr_clr_i), .tx_vld_o(tx_vld_o),
        .tx_data_o(tx_data_o), .txrdy_i(txrdy_i), .rx_vld_i(rx_vld_i), .rx_data_i(rx_data_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    bit         m_in_flight, m_seen_low, m_ovr, m_tx_vld;
    logic [7:0] m_tx_data;

    // rxtx emulator
    int         emu_pend, emu_low;
    bit         hold_low, long_frame;
    logic [7:0] tx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_txq.delete();
        m_rxq.delete();
        m_in_flight = 1'b0;
        m_seen_low  = 1'b0;
        m_ovr       = 1'b0;
        m_tx_vld    = 1'b0;
        m_tx_data   = 8'h00;
    endtask

    task automatic compare_all();
        chk("tx_vld", tx_vld_o, m_tx_vld);
        chk("tx_data", tx_data_o, m_tx_data);
        chk("tx_level", tx_level_o, m_txq.size());
        chk("tx_full", tx_full_o, m_txq.size() == DEPTH);
        chk("rx_level", rx_level_o, m_rxq.size());
        chk("rx_empty", rx_empty_o, m_rxq.size() == 0);
        chk("rx_overrun", rx_overrun_o, m_ovr);
        if (m_rxq.size() > 0) chk("rd_data", rd_data_o, m_rxq[0]);
    endtask

    // One clock: advance the model with the inputs seen at the edge, compare, update emulator.
    task automatic step();
        bit launch, tpush, rpop, rpush, oset;
        logic [7:0] ld;
        @(posedge clk_i);
        #1;
        if (!rst_i) begin
            launch = !m_in_flight && (m_txq.size() > 0) && txrdy_i;
            ld = launch ? m_txq[0] : 8'h00;
            if (m_in_flight) begin
                if (!m_seen_low) begin
                    if (!txrdy_i) m_seen_low = 1'b1;
                end else if (txrdy_i) begin
                    m_in_flight = 1'b0;
                end
            end
            tpush = wr_en_i && (m_txq.size() < DEPTH || launch);
            if (launch) begin
                void'(m_txq.pop_front());
                m_in_flight = 1'b1;
                m_seen_low  = 1'b0;
            end
            if (tpush) m_txq.push_back(wr_data_i);
            m_tx_vld  = launch;
            m_tx_data = ld;

            rpop  = rd_en_i && (m_rxq.size() > 0);
            rpush = rx_vld_i && (m_rxq.size() < DEPTH || rd_en_i);
            oset  = rx_vld_i && (m_rxq.size() == DEPTH) && !rd_en_i;
            if (rpop) void'(m_rxq.pop_front());
            if (rpush) m_rxq.push_back(rx_data_i);
            m_ovr = oset || (m_ovr && !ovr_clr_i);
        end
        compare_all();

        if (tx_vld_o) begin
            tx_log.push_back(tx_data_o);
            emu_pend = $urandom_range(0, 2);
            emu_low  = long_frame ? 20 : $urandom_range(1, 6);
        end
        if (emu_pend > 0) begin
            emu_pend--;
            txrdy_i = 1'b1;
        end else if (emu_low > 0) begin
            emu_low--;
            txrdy_i = 1'b0;
        end else begin
            txrdy_i = 1'b1;
        end
        if (hold_low) txrdy_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        wr_en_i = 1'b0; rd_en_i = 1'b0; rx_vld_i = 1'b0; ovr_clr_i = 1'b0;
        #1;
        model_clear();
        chk("rst_tx_vld", tx_vld_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_tx_full", tx_full_o, 0);
        chk("rst_tx_level", tx_level_o, 0);
        chk("rst_rx_empty", rx_empty_o, 1);
        chk("rst_rx_level", rx_level_o, 0);
        chk("rst_rx_overrun", rx_overrun_o, 0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_txq.size() > 0 || m_in_flight || emu_pend > 0 || emu_low > 0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] b;
        int n;
        model_clear();
        emu_pend = 0; emu_low = 0; hold_low = 1'b0; long_frame = 1'b0;
        #2;
        do_reset();

        // Single byte: level, launch pulse timing and data
        tx_log.delete();
        wr_en_i = 1'b1; wr_data_i = 8'hA5;
        step();
        wr_en_i = 1'b0;
        chk("a5_level_after_push", tx_level_o, 1);
        chk("a5_no_vld_yet", tx_vld_o, 0);
        step();
        chk("a5_vld", tx_vld_o, 1);
        chk("a5_data", tx_data_o, 8'hA5);
        chk("a5_level_popped", tx_level_o, 0);
        step();
        chk("a5_vld_one_cycle", tx_vld_o, 0);
        wait_idle();
        chk("a5_log_size", tx_log.size(), 1);
        if (tx_log.size() > 0) chk("a5_log", tx_log[0], 8'hA5);

        // Fill TX while the transmitter is held busy, then drain in order
        tx_log.delete();
        hold_low = 1'b1; txrdy_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wr_data_i = 8'(i + 1);
            step();
        end
        chk("tx_full_16", tx_full_o, 1);
        chk("tx_level_16", tx_level_o, 16);
        wr_data_i = 8'hFF;
        step();
        wr_en_i = 1'b0;
        chk("tx_17th_ignored", tx_level_o, 16);
        hold_low = 1'b0;
        wait_idle();
        chk("tx_log_size", tx_log.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < tx_log.size()) chk("tx_order", tx_log[i], i + 1);

        // RX overrun, drain, clear
        for (int i = 0; i < 17; i++) begin
            rx_vld_i = 1'b1; rx_data_i = 8'(8'h20 + i);
            step();
        end
        rx_vld_i = 1'b0;
        chk("rx_level_16", rx_level_o, 16);
        chk("rx_overrun_set", rx_overrun_o, 1);
        for (int i = 0; i < 16; i++) begin
            chk("rx_drain", rd_data_o, 8'h20 + i);
            rd_en_i = 1'b1;
            step();
        end
        rd_en_i = 1'b0;
        chk("rx_drained_empty", rx_empty_o, 1);
        chk("rx_overrun_sticky", rx_overrun_o, 1);
        rd_en_i = 1'b1;
        step();
        rd_en_i = 1'b0;
        chk("rx_pop_empty_ignored", rx_level_o, 0);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("rx_overrun_cleared", rx_overrun_o, 0);

        // Full RX with simultaneous push and pop: nothing dropped
        for (int i = 0; i < 16; i++) begin
            rx_vld_i = 1'b1; rx_data_i = 8'(8'h40 + i);
            step();
        end
        rd_en_i = 1'b1; rx_data_i = 8'h55;
        step();
        rx_vld_i = 1'b0; rd_en_i = 1'b0;
        chk("rx_full_pushpop_level", rx_level_o, 16);
        chk("rx_full_pushpop_ovr", rx_overrun_o, 0);
        chk("rx_full_pushpop_head", rd_data_o, 8'h41);
        for (int i = 0; i < 16; i++) begin
            b = rd_data_o;
            rd_en_i = 1'b1;
            step();
        end
        rd_en_i = 1'b0;
        chk("rx_newest_55", b, 8'h55);

        // Wrap-around with single-entry occupancy
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            rx_vld_i = 1'b1; rx_data_i = b;
            wr_en_i = 1'b1; wr_data_i = ~b;
            step();
            rx_vld_i = 1'b0; wr_en_i = 1'b0;
            chk("wrap_rx_level", rx_level_o <= 1, 1);
            chk("wrap_rx_data", rd_data_o, b);
            rd_en_i = 1'b1;
            step();
            rd_en_i = 1'b0;
            chk("wrap_tx_level", tx_level_o <= 1, 1);
            wait_idle();
        end

        // Reset while a frame is in flight with 3 bytes queued
        long_frame = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en_i = 1'b1; wr_data_i = 8'(8'hB0 + i);
            step();
        end
        wr_en_i = 1'b0;
        chk("mid_queued_3", tx_level_o, 3);
        n = 0;
        while (txrdy_i && n < 10) begin
            step();
            n++;
        end
        chk("mid_frame_busy", txrdy_i, 0);
        do_reset();
        tx_log.delete();
        wr_en_i = 1'b1; wr_data_i = 8'h3C;
        step();
        wr_en_i = 1'b0;
        n = 0;
        while (!txrdy_i && n < 40) begin
            chk("mid_no_launch_busy", tx_vld_o, 0);
            step();
            n++;
        end
        long_frame = 1'b0;
        wait_idle();
        chk("mid_log_size", tx_log.size(), 1);
        if (tx_log.size() > 0) chk("mid_log_3c", tx_log[0], 8'h3C);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                wr_en_i   = ($urandom_range(0, 2) == 0);
                wr_data_i = 8'($urandom);
                rd_en_i   = ($urandom_range(0, 2) == 0);
                rx_vld_i  = ($urandom_range(0, 1) == 0);
                rx_data_i = 8'($urandom);
                ovr_clr_i = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        wr_en_i = 1'b0; rd_en_i = 1'b0; rx_vld_i = 1'b0; ovr_clr_i = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
